// File: rtl/i2c_word_reader_pkg.sv
// i2c_word_reader_pkg: FSM states, R/W bit constants and counter widths shared by the I2C reader.
package i2c_word_reader_pkg;
  // Enum order is the bus sequence; the FSM advances by incrementing the state.
  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_WR_ADDR, ST_WR_REG, ST_RESTART, ST_RD_ADDR, ST_RD_HI, ST_RD_LO, ST_STOP
  } state_e;
  localparam logic RW_W = 1'b0;
  localparam logic RW_R = 1'b1;
  localparam int QW = 2;
  localparam int BW = 4;
  function automatic logic is_tx(state_e s);
    return s inside {ST_WR_ADDR, ST_WR_REG, ST_RD_ADDR};
  endfunction
  function automatic logic is_rx(state_e s);
    return s inside {ST_RD_HI, ST_RD_LO};
  endfunction
endpackage

// File: rtl/i2c_word_reader_tick_gen.sv
// i2c_word_reader_tick_gen: CLK_DIV prescaler emitting a quarter-period strobe and quarter index.
module i2c_word_reader_tick_gen
  import i2c_word_reader_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic          stb,
  output logic [QW-1:0] qidx
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] q_q, q_d;
  always_comb begin
    stb   = en && cnt_q == CW'(CLK_DIV - 1);
    cnt_d = (clr || stb) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    q_d   = clr ? '0 : stb ? q_q + 1'b1 : q_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      q_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end
  assign qidx = q_q;
endmodule

// File: rtl/i2c_word_reader.sv
// i2c_word_reader: I2C master reading one 16-bit big-endian register from a fixed slave.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL during the high phase.
module i2c_word_reader
  import i2c_word_reader_pkg::*;
#(
  parameter int         CLK_DIV  = 250,
  parameter logic [6:0] DEV_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  reg_addr,
  input  logic        sda_in,
  input  logic        scl_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        busy,
  output logic        ack_err
);
  state_e          state_q, state_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [7:0]      reg_q, reg_d, tx_byte;
  logic [15:0]     rx_q, rx_d, data_q, data_d;
  logic            dv_q, dv_d, err_q, err_d;
  logic [1:0]      sda_s_q;
  logic [QW-1:0]   q;
  logic            stb, hold, sample, bit_end, last, tx_bit, sda_s;

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_s_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) scl_s_q <= 2'b11;
    else scl_s_q <= {scl_s_q[0], scl_in};
  end
  assign hold = q == 2'd1 && !scl_s_q[1];
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign hold = 1'b0;
`endif

  i2c_word_reader_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (busy && !hold),
    .clr  (!busy),
    .stb  (stb),
    .qidx (q)
  );

  assign busy    = state_q != ST_IDLE;
  assign sda_s   = sda_s_q[1];
  assign sample  = stb && q == 2'd2;
  assign bit_end = stb && q == 2'd3;
  assign last    = bit_q == BW'(8);
  assign tx_byte = state_q == ST_WR_ADDR ? {DEV_ADDR, RW_W} : state_q == ST_WR_REG ? reg_q : {DEV_ADDR, RW_R};
  assign tx_bit  = tx_byte[~bit_q[2:0]];

  always_comb begin
    scl_oe = state_q == ST_IDLE ? 1'b0 : state_q == ST_START ? q == 2'd3 :
             state_q == ST_STOP ? q == 2'd0 : (q == 2'd0 || q == 2'd3);
    sda_oe = state_q inside {ST_START, ST_RESTART} ? q[1] : state_q == ST_STOP ? !q[1] :
             is_tx(state_q) ? !last && !tx_bit : state_q == ST_RD_HI && last;
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    reg_d   = reg_q;
    rx_d    = rx_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    err_d   = err_q;
    if (state_q == ST_IDLE && start) begin
      state_d = ST_START;
      bit_d   = '0;
      reg_d   = reg_addr;
      err_d   = 1'b0;
    end
    if (sample && last && is_tx(state_q) && sda_s) err_d = 1'b1;
    if (sample && !last && is_rx(state_q)) rx_d = {rx_q[14:0], sda_s};
    if (bit_end) begin
      bit_d = bit_q + 1'b1;
      if (last || !(is_tx(state_q) || is_rx(state_q))) begin
        bit_d   = '0;
        state_d = state_q == ST_STOP ? ST_IDLE : err_q ? ST_STOP : state_e'(state_q + 4'd1);
      end
      if (state_q == ST_STOP) begin
        dv_d   = !err_q;
        data_d = err_q ? data_q : rx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      reg_q   <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      sda_s_q <= 2'b11;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      reg_q   <= reg_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      sda_s_q <= {sda_s_q[0], sda_in};
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign ack_err    = err_q;
endmodule

// File: tb/tb_i2c_word_reader.sv
// tb_i2c_word_reader: open-drain bus with behavioural register slave; scoreboard checks each transaction.
module tb_i2c_word_reader;
  localparam int D = 4;
  localparam logic [6:0] DEV = 7'h48;

  typedef struct {
    logic [15:0] data;
    logic        dv;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] reg_addr = '0;
  logic scl_oe, sda_oe, data_valid, busy, ack_err;
  logic [15:0] data;
  logic sdrv = 1'b0;
  wire scl_l = !scl_oe;
  wire sda_l = !(sda_oe || sdrv);

  int n_chk = 0, n_fail = 0;
  exp_t exp_q[$];
  logic [15:0] mem [256];
  logic [15:0] last_good = '0;
  logic [6:0] saddr = DEV;

  // slave state
  int ph = 0, bc = 0, byte_n = 0, ns = 0, np = 0;
  logic [7:0] sh = '0, ptr = '0, txb;
  logic [15:0] word = '0;
  logic p_scl = 1'b1, p_sda = 1'b1;
  logic [7:0] wr_q[$];
  bit ma_q[$];

  i2c_word_reader #(.CLK_DIV(D), .DEV_ADDR(DEV)) dut (
    .clk(clk), .reset(reset), .start(start), .reg_addr(reg_addr),
    .sda_in(sda_l), .scl_in(scl_l), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .data(data), .data_valid(data_valid), .busy(busy), .ack_err(ack_err)
  );

  always #5 clk = !clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural slave: acks its address and the pointer, returns mem[ptr] big-endian.
  always @(sda_l or scl_l or reset) begin
    if (!reset) begin
      ph = 0;
      sdrv = 1'b0;
    end else if (scl_l && p_scl && sda_l != p_sda) begin
      if (!sda_l) begin ph = 1; bc = 0; ns++; end
      else begin ph = 0; sdrv = 1'b0; np++; end
    end else if (scl_l && !p_scl && ph != 0) begin
      if (bc < 8 && ph != 3) sh = {sh[6:0], sda_l};
      if (bc == 8 && ph == 3) ma_q.push_back(sda_l);
      bc++;
    end else if (!scl_l && p_scl && ph != 0) begin
      if (bc == 8) begin
        if (ph == 3) sdrv = 1'b0;
        else begin
          wr_q.push_back(sh);
          if (ph == 1 && sh[7:1] != saddr) begin ph = 0; sdrv = 1'b0; end
          else sdrv = 1'b1;
        end
      end else if (bc == 9) begin
        bc = 0;
        sdrv = 1'b0;
        if (ph == 1) begin ph = sh[0] ? 3 : 2; byte_n = 0; word = mem[ptr]; end
        else if (ph == 2) ptr = sh;
        else if (ma_q.size() > 0 && ma_q[$]) ph = 0;
        else byte_n++;
      end
      if (ph == 3 && bc < 8) begin
        txb = byte_n == 0 ? word[15:8] : word[7:0];
        sdrv = !txb[3'(7 - bc)];
      end
    end
    p_sda = sda_l;
    p_scl = scl_l;
  end

  // Monitor: every completion (busy falling) is matched against the oldest expectation.
  logic bprev = 1'b0;
  int cyc = 0;
  always @(negedge clk) begin
    if (!reset) begin
      bprev <= 1'b0;
      cyc   <= 0;
    end else begin
      if (data_valid && !(bprev && !busy)) chk("dv_outside_completion", 32'(data_valid), 0);
      if (bprev && !busy) begin
        if (exp_q.size() == 0) chk("unexpected_completion", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("data_valid", 32'(data_valid), 32'(e.dv));
          chk("data", 32'(data), 32'(e.data));
          chk("ack_err", 32'(ack_err), 32'(e.err));
          chk("latency", cyc, e.cyc);
        end
        cyc <= 0;
      end else if (busy) cyc <= cyc + 1;
      bprev <= busy;
    end
  end

  task automatic do_txn(input logic [7:0] a, input logic [6:0] sa, input bit dup);
    exp_t e;
    bit ok;
    int n, ns0, np0, w0, m0;
    saddr = sa;
    ns0 = ns; np0 = np; w0 = wr_q.size(); m0 = ma_q.size();
    ok = sa == DEV;
    e.dv = ok;
    e.err = !ok;
    e.data = ok ? mem[a] : last_good;
    e.cyc = (ok ? 48 : 11) * 4 * D;
    if (ok) last_good = mem[a];
    @(negedge clk);
    reg_addr = a;
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    reg_addr = 8'($urandom);
    chk("busy_after_accept", 32'(busy), 1);
    chk("ack_err_cleared", 32'(ack_err), 0);
    if (dup) begin
      repeat (100) @(negedge clk);
      start = 1'b1;
      reg_addr = 8'h55;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (exp_q.size() > 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("bus_starts", ns - ns0, ok ? 2 : 1);
    chk("bus_stops", np - np0, 1);
    chk("bus_wr_bytes", wr_q.size() - w0, ok ? 3 : 1);
    if (wr_q.size() > w0) chk("addr_w_byte", 32'(wr_q[w0]), 32'({DEV, 1'b0}));
    if (ok && wr_q.size() == w0 + 3) begin
      chk("ptr_byte", 32'(wr_q[w0 + 1]), 32'(a));
      chk("addr_r_byte", 32'(wr_q[w0 + 2]), 32'({DEV, 1'b1}));
    end
    if (ok) begin
      chk("master_ack_count", ma_q.size() - m0, 2);
      if (ma_q.size() == m0 + 2) chk("master_ack_nack", 32'({ma_q[m0], ma_q[m0 + 1]}), 32'b01);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[3] = 16'hBEEF;
    #2 reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_scl_oe", 32'(scl_oe), 0);
    chk("rst_sda_oe", 32'(sda_oe), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_data_valid", 32'(data_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack_err", 32'(ack_err), 0);
    chk("rst_lines", 32'({scl_l, sda_l}), 32'b11);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_lines", 32'({scl_l, sda_l}), 32'b11);

    do_txn(8'h03, DEV, 1'b0);
    do_txn(8'($urandom), 7'h49, 1'b0);
    do_txn(8'h03, DEV, 1'b1);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      do_txn(8'($urandom), $urandom_range(0, 3) == 0 ? 7'h49 : DEV, $urandom_range(0, 1) == 1);
    end

    saddr = DEV;
    @(negedge clk);
    reg_addr = 8'h03;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (ph != 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rd_hi", ph, 3);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_scl_oe", 32'(scl_oe), 0);
    chk("abort_sda_oe", 32'(sda_oe), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_data", 32'(data), 0);
    chk("abort_lines", 32'({scl_l, sda_l}), 32'b11);
    last_good = '0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    do_txn(8'h03, DEV, 1'b0);
    do_txn(8'($urandom), DEV, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
